// File: rtl/mem_port_arbiter_if.sv
//==============================================================================
// mem_port_arbiter_if : request/ack bundle for both requesters plus memory port
// Revision 1.0
//==============================================================================
`default_nettype none

interface mem_port_arbiter_if;
  logic [1:0]  r0_cmd;
  logic [8:0]  r0_addr;
  logic [15:0] r0_wdata;
  logic        r0_ack;
  logic        r0_gnt;
  logic [1:0]  r1_cmd;
  logic [8:0]  r1_addr;
  logic [15:0] r1_wdata;
  logic        r1_ack;
  logic        r1_gnt;
  logic [15:0] rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  // Arbiter side
  modport slave (
    input  r0_cmd, r0_addr, r0_wdata,
    input  r1_cmd, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_ack, r0_gnt, r1_ack, r1_gnt,
    output rdata, mem_cmd, mem_addr, mem_wdata, busy
  );

  // Requester/memory environment side
  modport master (
    output r0_cmd, r0_addr, r0_wdata,
    output r1_cmd, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_ack, r0_gnt, r1_ack, r1_gnt,
    input  rdata, mem_cmd, mem_addr, mem_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// mem_port_arbiter : round-robin two-requester arbiter for a 9b/16b memory port
// Revision 1.0
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;

  state_t      state;
  logic        owner;
  logic        last_owner;
  logic [3:0]  wait_cnt;
  logic [1:0]  lat_cmd;
  logic        r0_ack_q;
  logic        r1_ack_q;
  logic        r0_gnt_q;
  logic        r1_gnt_q;
  logic [15:0] rdata_q;
  logic [1:0]  mem_cmd_q;
  logic [8:0]  mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        busy_q;

  logic        valid0;
  logic        valid1;
  logic        any_req;
  logic        winner;
  logic [1:0]  sel_cmd;
  logic [8:0]  sel_addr;
  logic [15:0] sel_wdata;

  // Only 01 and 10 are real commands; 11 behaves like 00.
  assign valid0  = bus.r0_cmd[0] ^ bus.r0_cmd[1];
  assign valid1  = bus.r1_cmd[0] ^ bus.r1_cmd[1];
  assign any_req = valid0 | valid1;

  always_comb begin
    winner = 1'b0;
    if (valid0 && valid1) begin
      winner = ~last_owner;
    end else begin
      winner = valid1;
    end
  end

  assign sel_cmd   = winner ? bus.r1_cmd   : bus.r0_cmd;
  assign sel_addr  = winner ? bus.r1_addr  : bus.r0_addr;
  assign sel_wdata = winner ? bus.r1_wdata : bus.r0_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      wait_cnt    <= 4'd0;
      lat_cmd     <= CMD_NONE;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_gnt_q    <= 1'b0;
      r1_gnt_q    <= 1'b0;
      rdata_q     <= 16'd0;
      mem_cmd_q   <= CMD_NONE;
      mem_addr_q  <= 9'd0;
      mem_wdata_q <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_cmd     <= sel_cmd;
            mem_cmd_q   <= sel_cmd;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            owner       <= winner;
            last_owner  <= winner;
            wait_cnt    <= WAIT_INIT;
            r0_gnt_q    <= ~winner;
            r1_gnt_q    <= winner;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // mem_rdata is valid on this, the final ACCESS cycle.
            if (lat_cmd == CMD_READ) begin
              rdata_q <= bus.mem_rdata;
            end
            mem_cmd_q <= CMD_NONE;
            r0_ack_q  <= ~owner;
            r1_ack_q  <= owner;
            state     <= RESP;
          end
        end
        RESP: begin
          r0_ack_q <= 1'b0;
          r1_ack_q <= 1'b0;
          r0_gnt_q <= 1'b0;
          r1_gnt_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          mem_cmd_q <= CMD_NONE;
          r0_ack_q  <= 1'b0;
          r1_ack_q  <= 1'b0;
          r0_gnt_q  <= 1'b0;
          r1_gnt_q  <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.r0_ack    = r0_ack_q;
  assign bus.r1_ack    = r1_ack_q;
  assign bus.r0_gnt    = r0_gnt_q;
  assign bus.r1_gnt    = r1_gnt_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_cmd   = mem_cmd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// tb_mem_port_arbiter : vector table, corner sequences and randomized model check
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  r0_cmd;
  logic [8:0]  r0_addr;
  logic [15:0] r0_wdata;
  logic [1:0]  r1_cmd;
  logic [8:0]  r1_addr;
  logic [15:0] r1_wdata;
  logic [15:0] mem_rdata;

  // {ack0, ack1, gnt0, gnt1, mem_cmd, mem_addr, mem_wdata, busy, rdata}
  logic [47:0] act [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three instances: WAIT_CYCLES = 1, 0, 3, sharing the same stimulus.
  for (genvar i = 0; i < 3; i++) begin : g_dut
    mem_port_arbiter_if bus ();
    assign bus.r0_cmd    = r0_cmd;
    assign bus.r0_addr   = r0_addr;
    assign bus.r0_wdata  = r0_wdata;
    assign bus.r1_cmd    = r1_cmd;
    assign bus.r1_addr   = r1_addr;
    assign bus.r1_wdata  = r1_wdata;
    assign bus.mem_rdata = mem_rdata;
    mem_port_arbiter #(.WAIT_CYCLES(i == 0 ? 1 : (i == 1 ? 0 : 3))) u_dut (
      .clk   (clk),
      .reset (reset_n),
      .bus   (bus.slave)
    );
    assign act[i] = {bus.r0_ack, bus.r1_ack, bus.r0_gnt, bus.r1_gnt, bus.mem_cmd,
                     bus.mem_addr, bus.mem_wdata, bus.busy, bus.rdata};
  end

  function automatic logic [47:0] pk(input logic a0, input logic a1, input logic g0,
                                     input logic g1, input logic [1:0] mc,
                                     input logic [8:0] ma, input logic [15:0] mw,
                                     input logic bz, input logic [15:0] rd);
    return {a0, a1, g0, g1, mc, ma, mw, bz, rd};
  endfunction

  task automatic check(input string name, input int idx, input logic [47:0] got,
                       input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  c0;
    logic [8:0]  a0;
    logic [15:0] w0;
    logic [1:0]  c1;
    logic [8:0]  a1;
    logic [15:0] w1;
    logic [15:0] mrd;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input logic [1:0] c0, input logic [8:0] a0,
                              input logic [15:0] w0, input logic [1:0] c1,
                              input logic [8:0] a1, input logic [15:0] w1,
                              input logic [15:0] mrd, input logic [47:0] exp);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.w0 = w0;
    v.c1 = c1; v.a1 = a1; v.w1 = w1;
    v.mrd = mrd; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Transaction-timeline reference model: each access occupies elapsed cycles
  // 1..W+1 (memory cycle), W+2 (response), and frees the port one cycle later.
  int          wv     [3];
  bit          m_act  [3];
  int          m_el   [3];
  bit          m_own  [3];
  bit          m_last [3];
  logic [1:0]  m_cmd  [3];
  logic [8:0]  m_addr [3];
  logic [15:0] m_wd   [3];
  logic [15:0] m_rd   [3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_el[i] = 0; m_own[i] = 0; m_last[i] = 1;
      m_cmd[i] = 2'b00; m_addr[i] = 9'd0; m_wd[i] = 16'd0; m_rd[i] = 16'd0;
    end
  endfunction

  function automatic void model_edge(input int i);
    bit v0, v1;
    v0 = (r0_cmd == 2'b01) || (r0_cmd == 2'b10);
    v1 = (r1_cmd == 2'b01) || (r1_cmd == 2'b10);
    if (m_act[i]) begin
      m_el[i] = m_el[i] + 1;
      if (m_el[i] == wv[i] + 2 && m_cmd[i] == 2'b01) m_rd[i] = mem_rdata;
      if (m_el[i] == wv[i] + 3) m_act[i] = 0;
    end else if (v0 || v1) begin
      m_own[i]  = (v0 && v1) ? !m_last[i] : v1;
      m_last[i] = m_own[i];
      m_act[i]  = 1;
      m_el[i]   = 1;
      m_cmd[i]  = m_own[i] ? r1_cmd : r0_cmd;
      m_addr[i] = m_own[i] ? r1_addr : r0_addr;
      m_wd[i]   = m_own[i] ? r1_wdata : r0_wdata;
    end
  endfunction

  function automatic logic [47:0] model_out(input int i);
    bit acc, rsp;
    acc = m_act[i] && (m_el[i] <= wv[i] + 1);
    rsp = m_act[i] && (m_el[i] == wv[i] + 2);
    return pk(rsp && !m_own[i], rsp && m_own[i], (acc || rsp) && !m_own[i],
              (acc || rsp) && m_own[i], acc ? m_cmd[i] : 2'b00, m_addr[i], m_wd[i],
              m_act[i], m_rd[i]);
  endfunction

  task automatic set_in(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] w0,
                        input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] w1,
                        input logic [15:0] mrd);
    r0_cmd = c0; r0_addr = a0; r0_wdata = w0;
    r1_cmd = c1; r1_addr = a1; r1_wdata = w1;
    mem_rdata = mrd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] rd;
    logic        own;
    logic [8:0]  a;
    logic [15:0] zero16;
    int          first_ack [3];

    wv[0] = 1; wv[1] = 0; wv[2] = 3;
    zero16 = 16'd0;
    reset_n = 1'b0;
    set_in(2'b00, 9'd0, 16'd0, 2'b00, 9'd0, 16'd0, 16'd0);

    // ---- vector table (WAIT_CYCLES = 1 instance) ----
    rd = 16'd0;
    for (int t = 0; t < 4; t++) begin
      own = t[0];
      a = own ? 9'h020 : 9'h010;
      add(2'b01, 9'h010, 0, 2'b01, 9'h020, 0, 0, pk(0, 0, !own, own, 2'b01, a, 0, 1, rd));
      add(2'b01, 9'h010, 0, 2'b01, 9'h020, 0, 0, pk(0, 0, !own, own, 2'b01, a, 0, 1, rd));
      rd = 16'hA000 + 16'(t);
      add(2'b01, 9'h010, 0, 2'b01, 9'h020, 0, rd, pk(!own, own, !own, own, 2'b00, a, 0, 1, rd));
      add(2'b01, 9'h010, 0, 2'b01, 9'h020, 0, 0, pk(0, 0, 0, 0, 2'b00, a, 0, 0, rd));
    end
    add(2'b01, 9'h005, 0, 2'b00, 0, 0, 0, pk(0, 0, 1, 0, 2'b01, 9'h005, 0, 1, rd));
    add(2'b01, 9'h005, 0, 2'b00, 0, 0, 0, pk(0, 0, 1, 0, 2'b01, 9'h005, 0, 1, rd));
    add(2'b01, 9'h005, 0, 2'b00, 0, 0, 16'hBEEF, pk(1, 0, 1, 0, 2'b00, 9'h005, 0, 1, 16'hBEEF));
    add(2'b00, 9'h005, 0, 2'b00, 0, 0, 0, pk(0, 0, 0, 0, 2'b00, 9'h005, 0, 0, 16'hBEEF));
    add(0, 0, 0, 2'b10, 9'h1FF, 16'h1234, 0, pk(0, 0, 0, 1, 2'b10, 9'h1FF, 16'h1234, 1, 16'hBEEF));
    add(0, 0, 0, 2'b10, 9'h1FF, 16'h1234, 0, pk(0, 0, 0, 1, 2'b10, 9'h1FF, 16'h1234, 1, 16'hBEEF));
    add(0, 0, 0, 2'b10, 9'h1FF, 16'h1234, 16'hDEAD, pk(0, 1, 0, 1, 2'b00, 9'h1FF, 16'h1234, 1, 16'hBEEF));
    add(0, 0, 0, 2'b00, 9'h1FF, 16'h1234, 0, pk(0, 0, 0, 0, 2'b00, 9'h1FF, 16'h1234, 0, 16'hBEEF));
    add(0, 0, 0, 2'b01, 9'h1FF, 16'h1234, 0, pk(0, 0, 0, 1, 2'b01, 9'h1FF, 16'h1234, 1, 16'hBEEF));
    add(0, 0, 0, 2'b01, 9'h1FF, 16'h1234, 0, pk(0, 0, 0, 1, 2'b01, 9'h1FF, 16'h1234, 1, 16'hBEEF));
    add(0, 0, 0, 2'b01, 9'h1FF, 16'h1234, 16'h1234, pk(0, 1, 0, 1, 2'b00, 9'h1FF, 16'h1234, 1, 16'h1234));
    add(0, 0, 0, 2'b00, 9'h1FF, 16'h1234, 0, pk(0, 0, 0, 0, 2'b00, 9'h1FF, 16'h1234, 0, 16'h1234));
    for (int k = 0; k < 3; k++)
      add(2'b11, 9'h0AA, 16'hFFFF, 2'b00, 0, 0, 0, pk(0, 0, 0, 0, 2'b00, 9'h1FF, 16'h1234, 0, 16'h1234));
    add(0, 0, 0, 2'b01, 9'h0AA, 0, 0, pk(0, 0, 0, 1, 2'b01, 9'h0AA, 0, 1, 16'h1234));
    add(0, 0, 0, 2'b00, 9'h0AB, 0, 0, pk(0, 0, 0, 1, 2'b01, 9'h0AA, 0, 1, 16'h1234));
    add(0, 0, 0, 2'b00, 9'h0AB, 0, 16'h7777, pk(0, 1, 0, 1, 2'b00, 9'h0AA, 0, 1, 16'h7777));
    add(0, 0, 0, 2'b00, 9'h0AB, 0, 0, pk(0, 0, 0, 0, 2'b00, 9'h0AA, 0, 0, 16'h7777));

    do_reset();
    for (int i = 0; i < 3; i++) check("reset_state", i, act[i], 48'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].c0, vecs[i].a0, vecs[i].w0, vecs[i].c1, vecs[i].a1, vecs[i].w1,
             vecs[i].mrd);
      @(posedge clk);
      #1;
      check("vec", i, act[0], vecs[i].exp);
    end

    // ---- asynchronous reset during the second ACCESS cycle ----
    set_in(2'b01, 9'h033, 16'h0, 2'b00, 9'h0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    check("mid_pre", 0, act[0], pk(0, 0, 1, 0, 2'b01, 9'h033, 0, 1, 16'h7777));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("mid_reset", i, act[i], 48'd0);
    @(negedge clk);
    reset_n = 1'b1;
    set_in(2'b01, 9'h044, 16'h0, 2'b01, 9'h055, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check("post_reset_grant", i, act[i], pk(0, 0, 1, 0, 2'b01, 9'h044, 0, 1, 0));
    set_in(2'b00, 9'h0, 16'h0, 2'b00, 9'h0, 16'h0, 16'h0);

    // ---- ack latency for each WAIT_CYCLES setting ----
    do_reset();
    set_in(2'b01, 9'h007, 16'h0, 2'b00, 9'h0, 16'h0, 16'h5A5A);
    for (int i = 0; i < 3; i++) first_ack[i] = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      r0_cmd = 2'b00;
      for (int i = 0; i < 3; i++)
        if (first_ack[i] < 0 && act[i][47]) first_ack[i] = k;
    end
    check_int("latency", 0, first_ack[0], 3);
    check_int("latency", 1, first_ack[1], 2);
    check_int("latency", 2, first_ack[2], 5);
    for (int i = 0; i < 3; i++)
      check("latency_rdata", i, {32'd0, act[i][15:0]}, {32'd0, 16'h5A5A});

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      set_in(2'($urandom_range(0, 3)), 9'($urandom), 16'($urandom),
             2'($urandom_range(0, 3)), 9'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      for (int i = 0; i < 3; i++) check("random", n * 3 + i, act[i], model_out(i));
    end

    if (zero16 != 16'd0) $display("unexpected");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
